// File: rtl/riscv_biu_pkg.sv
`default_nettype none
// ======================================================================
// riscv_biu_pkg : shared AHB-Lite codes, BIU state enum and helpers. Rev 1.0
// ======================================================================
package riscv_biu_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001,
      HBURST_WRAP4  = 3'b010,
      HBURST_INCR4  = 3'b011,
      HBURST_WRAP8  = 3'b100,
      HBURST_INCR8  = 3'b101,
      HBURST_WRAP16 = 3'b110,
      HBURST_INCR16 = 3'b111
   } hburst_t;

   typedef enum logic [2:0] {
      HSIZE_BYTE  = 3'b000,
      HSIZE_HWORD = 3'b001,
      HSIZE_WORD  = 3'b010,
      HSIZE_DWORD = 3'b011
   } hsize_t;

   typedef enum logic {
      HRESP_OKAY  = 1'b0,
      HRESP_ERROR = 1'b1
   } hresp_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ADDR = 2'b01,
      ST_DATA = 2'b10,
      ST_ERR  = 2'b11
   } state_t;

   // Low address bits that must be zero for a transfer of the given size.
   function automatic logic [2:0] size_mask(input logic [2:0] size);
      case (size)
         3'd0:    size_mask = 3'b000;
         3'd1:    size_mask = 3'b001;
         3'd2:    size_mask = 3'b011;
         default: size_mask = 3'b111;
      endcase
   endfunction

   function automatic int tmo_width(input int timeout);
      int w;
      w = $clog2(timeout + 1);
      if (w < 8)  w = 8;
      if (w > 16) w = 16;
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_biu_if.sv
`default_nettype none
// ======================================================================
// riscv_biu_if : AHB-Lite master/slave signal bundle. Rev 1.0
// ======================================================================
interface riscv_biu_if #(
   parameter int XLEN = 64,
   parameter int PLEN = 64
);
   logic            HSEL;
   logic [1:0]      HTRANS;
   logic [PLEN-1:0] HADDR;
   logic            HWRITE;
   logic [2:0]      HSIZE;
   logic [2:0]      HBURST;
   logic [3:0]      HPROT;
   logic            HMASTLOCK;
   logic [XLEN-1:0] HWDATA;
   logic [XLEN-1:0] HRDATA;
   logic            HREADY;
   logic            HRESP;

   modport master (
      output HSEL, HTRANS, HADDR, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      input  HSEL, HTRANS, HADDR, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
      output HRDATA, HREADY, HRESP
   );
endinterface
`default_nettype wire

// File: rtl/riscv_biu_align.sv
`default_nettype none
// ======================================================================
// riscv_biu_align : combinational size/address misalignment check. Rev 1.0
// ======================================================================
module riscv_biu_align
   import riscv_biu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  wire [2:0] padr_i,
   input  wire [2:0] psize_i,
   output logic      misaligned_o
);
   localparam logic [2:0] MAX_SIZE = 3'($clog2(XLEN / 8));

   always_comb begin
      misaligned_o = (psize_i > MAX_SIZE) || ((padr_i & size_mask(psize_i)) != 3'b000);
   end
endmodule
`default_nettype wire

// File: rtl/riscv_biu.sv
`default_nettype none
// ======================================================================
// riscv_biu : MMU-to-AHB-Lite single-transfer master; RISCV_BIU_TIMEOUT_EN adds a wait-state abort. Rev 1.0
// ======================================================================
module riscv_biu
   import riscv_biu_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int PLEN    = 64,
   parameter int TIMEOUT = 255
) (
   input  wire              clk_i,
   input  wire              rst_i,
   input  wire              clr_i,
   input  wire              preq_i,
   input  wire [PLEN-1:0]   padr_i,
   input  wire [2:0]        psize_i,
   input  wire              plock_i,
   input  wire [2:0]        pprot_i,
   input  wire              pwe_i,
   input  wire [XLEN-1:0]   pd_i,
   output logic [XLEN-1:0]  pq_o,
   output logic             pack_o,
   output logic             perr_o,
   riscv_biu_if.master      ahb
);
   state_t          state_q;
   htrans_t         htrans_q;
   logic            hsel_q;
   logic [PLEN-1:0] haddr_q;
   logic            hwrite_q;
   logic [2:0]      hsize_q;
   logic [3:0]      hprot_q;
   logic            hmastlock_q;
   logic [XLEN-1:0] hwdata_q;
   logic [XLEN-1:0] wdata_q;
   logic [XLEN-1:0] pq_q;
   logic            pack_q;
   logic            perr_q;
   logic            clr_q;
   logic            misaligned;
   logic            suppress;
   logic            timeout;

   riscv_biu_align #(.XLEN(XLEN)) u_align (
      .padr_i       (padr_i[2:0]),
      .psize_i      (psize_i),
      .misaligned_o (misaligned)
   );

   // A clear seen at any point of an in-flight transfer silences its termination pulse.
   assign suppress = clr_i | clr_q;

`ifdef RISCV_BIU_TIMEOUT_EN
   localparam int CNT_W = tmo_width(TIMEOUT);
   logic [CNT_W-1:0] tmo_cnt_q;
   logic             tmo_stay;

   assign timeout  = ((state_q == ST_DATA) || (state_q == ST_ERR)) && !ahb.HREADY &&
                     (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
   assign tmo_stay = !ahb.HREADY && !timeout &&
                     ((state_q == ST_ERR) || ((state_q == ST_DATA) && (ahb.HRESP == HRESP_OKAY)));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         htrans_q    <= HTRANS_IDLE;
         hsel_q      <= 1'b0;
         haddr_q     <= '0;
         hwrite_q    <= 1'b0;
         hsize_q     <= 3'b000;
         hprot_q     <= 4'b0000;
         hmastlock_q <= 1'b0;
         hwdata_q    <= '0;
         wdata_q     <= '0;
         pq_q        <= '0;
         pack_q      <= 1'b0;
         perr_q      <= 1'b0;
         clr_q       <= 1'b0;
`ifdef RISCV_BIU_TIMEOUT_EN
         tmo_cnt_q   <= '0;
`endif
      end else begin
         pack_q <= 1'b0;
         perr_q <= 1'b0;
`ifdef RISCV_BIU_TIMEOUT_EN
         tmo_cnt_q <= tmo_stay ? tmo_cnt_q + 1'b1 : '0;
`endif
         case (state_q)
            ST_IDLE: begin
               clr_q <= 1'b0;
               // The pulse holdoff keeps a request still held during its own ack from re-issuing.
               if (preq_i && !clr_i && !pack_q && !perr_q) begin
                  if (misaligned) begin
                     perr_q <= 1'b1;
                  end else begin
                     state_q     <= ST_ADDR;
                     htrans_q    <= HTRANS_NONSEQ;
                     hsel_q      <= 1'b1;
                     haddr_q     <= padr_i;
                     hwrite_q    <= pwe_i;
                     hsize_q     <= psize_i;
                     hprot_q     <= {pprot_i[2], 1'b0, pprot_i[1], pprot_i[0]};
                     hmastlock_q <= plock_i;
                     wdata_q     <= pd_i;
                  end
               end
            end
            ST_ADDR: begin
               if (clr_i) clr_q <= 1'b1;
               if (ahb.HREADY) begin
                  state_q     <= ST_DATA;
                  htrans_q    <= HTRANS_IDLE;
                  hmastlock_q <= 1'b0;
                  hwdata_q    <= wdata_q;
               end
            end
            ST_DATA: begin
               if (clr_i) clr_q <= 1'b1;
               if (ahb.HREADY) begin
                  state_q <= ST_IDLE;
                  hsel_q  <= 1'b0;
                  if (ahb.HRESP == HRESP_OKAY) begin
                     if (!hwrite_q) pq_q <= ahb.HRDATA;
                     pack_q <= !suppress;
                  end else begin
                     perr_q <= !suppress;
                  end
               end else if (ahb.HRESP == HRESP_ERROR) begin
                  state_q <= ST_ERR;
               end else if (timeout) begin
                  state_q <= ST_IDLE;
                  hsel_q  <= 1'b0;
                  perr_q  <= !suppress;
               end
            end
            default: begin
               if (clr_i) clr_q <= 1'b1;
               if (ahb.HREADY || timeout) begin
                  state_q <= ST_IDLE;
                  hsel_q  <= 1'b0;
                  perr_q  <= !suppress;
               end
            end
         endcase
      end
   end

   assign ahb.HSEL      = hsel_q;
   assign ahb.HTRANS    = htrans_q;
   assign ahb.HADDR     = haddr_q;
   assign ahb.HWRITE    = hwrite_q;
   assign ahb.HSIZE     = hsize_q;
   assign ahb.HBURST    = HBURST_SINGLE;
   assign ahb.HPROT     = hprot_q;
   assign ahb.HMASTLOCK = hmastlock_q;
   assign ahb.HWDATA    = hwdata_q;
   assign pq_o          = pq_q;
   assign pack_o        = pack_q;
   assign perr_o        = perr_q;
endmodule
`default_nettype wire

// File: tb/tb_riscv_biu.sv
`default_nettype none
// ======================================================================
// tb_riscv_biu : randomized self-checking bench for riscv_biu. Rev 1.0
// ======================================================================
module tb_riscv_biu;
   localparam int XLEN    = 64;
   localparam int PLEN    = 64;
   localparam int TIMEOUT = 4;
`ifdef RISCV_BIU_TIMEOUT_EN
   localparam int MAX_WAIT = 2;
`else
   localparam int MAX_WAIT = 4;
`endif

   logic            clk   = 1'b0;
   logic            rst   = 1'b1;
   logic            clr   = 1'b0;
   logic            preq  = 1'b0;
   logic [PLEN-1:0] padr  = '0;
   logic [2:0]      psize = 3'b000;
   logic            plock = 1'b0;
   logic [2:0]      pprot = 3'b000;
   logic            pwe   = 1'b0;
   logic [XLEN-1:0] pd    = '0;
   wire  [XLEN-1:0] pq;
   wire             pack;
   wire             perr;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] m_pq     = 64'd0;
   bit          pq_known = 1'b1;

   riscv_biu_if #(.XLEN(XLEN), .PLEN(PLEN)) ahb ();

   riscv_biu #(.XLEN(XLEN), .PLEN(PLEN), .TIMEOUT(TIMEOUT)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .clr_i   (clr),
      .preq_i  (preq),
      .padr_i  (padr),
      .psize_i (psize),
      .plock_i (plock),
      .pprot_i (pprot),
      .pwe_i   (pwe),
      .pd_i    (pd),
      .pq_o    (pq),
      .pack_o  (pack),
      .perr_o  (perr),
      .ahb     (ahb)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One MMU request plus the slave's response plan; the expected behaviour is derived
   // from the transaction rules (alignment, response kind, clear) rather than cycle state.
   task automatic xfer(input logic [63:0] addr, input logic [2:0] size, input bit we,
                       input logic [63:0] wd, input logic [63:0] rd, input int aw, input int nw,
                       input bit err, input bit do_clr, input bit lock, input logic [2:0] prot);
      bit         mis;
      logic [3:0] exp_prot;
      mis      = (size > 3) || ((addr % (64'd1 << size)) != 64'd0);
      exp_prot = {prot[2], 1'b0, prot[1], prot[0]};
      preq = 1'b1; padr = addr; psize = size; pwe = we; pd = wd; plock = lock; pprot = prot;
      ahb.HREADY = 1'b1; ahb.HRESP = 1'b0;
      step();
      if (mis) begin
         check_eq("mis_perr", perr, 1);
         check_eq("mis_pack", pack, 0);
         check_eq("mis_htrans", ahb.HTRANS, 2'b00);
         step();
         preq = 1'b0;
         check_eq("mis_pulse", perr, 0);
         check_eq("mis_idle", ahb.HTRANS, 2'b00);
         return;
      end
      check_eq("a_htrans", ahb.HTRANS, 2'b10);
      check_eq("a_hsel", ahb.HSEL, 1);
      check_eq("a_haddr", ahb.HADDR, addr);
      check_eq("a_hwrite", ahb.HWRITE, we);
      check_eq("a_hsize", ahb.HSIZE, size);
      check_eq("a_hburst", ahb.HBURST, 3'b000);
      check_eq("a_hprot", ahb.HPROT, exp_prot);
      check_eq("a_lock", ahb.HMASTLOCK, lock);
      for (int i = 0; i < aw; i++) begin
         ahb.HREADY = 1'b0;
         step();
         check_eq("a_hold", ahb.HTRANS, 2'b10);
         check_eq("a_hold_addr", ahb.HADDR, addr);
      end
      ahb.HREADY = 1'b1;
      step();
      check_eq("d_htrans", ahb.HTRANS, 2'b00);
      check_eq("d_lock", ahb.HMASTLOCK, 0);
      if (we) check_eq("d_hwdata", ahb.HWDATA, wd);
      if (do_clr) begin
         clr  = 1'b1;
         preq = 1'b0;
      end
      for (int i = 0; i < nw; i++) begin
         ahb.HREADY = 1'b0; ahb.HRESP = 1'b0; ahb.HRDATA = {$urandom, $urandom};
         step();
         clr = 1'b0;
         check_eq("d_wait", {pack, perr}, 2'b00);
      end
      if (err) begin
         ahb.HREADY = 1'b0; ahb.HRESP = 1'b1;
         step();
         clr = 1'b0;
         check_eq("e_first", {pack, perr}, 2'b00);
         ahb.HREADY = 1'b1; ahb.HRESP = 1'b1; ahb.HRDATA = rd;
         step();
      end else begin
         ahb.HREADY = 1'b1; ahb.HRESP = 1'b0; ahb.HRDATA = rd;
         step();
      end
      clr = 1'b0;
      ahb.HREADY = 1'b1; ahb.HRESP = 1'b0;
      check_eq("c_pack", pack, !err && !do_clr);
      check_eq("c_perr", perr, err && !do_clr);
      if (!we && !err) begin
         if (do_clr) pq_known = 1'b0;
         else begin
            m_pq     = rd;
            pq_known = 1'b1;
         end
      end
      if (pq_known) check_eq("c_pq", pq, m_pq);
      step();
      preq = 1'b0;
      check_eq("post_pulse", {pack, perr}, 2'b00);
      check_eq("post_idle", ahb.HTRANS, 2'b00);
   endtask

   initial begin
      logic [63:0] addr;
      logic [2:0]  size;
      ahb.HREADY = 1'b1; ahb.HRESP = 1'b0; ahb.HRDATA = '0;
      step();
      step();
      check_eq("rst_htrans", ahb.HTRANS, 2'b00);
      check_eq("rst_hsel", ahb.HSEL, 0);
      check_eq("rst_haddr", ahb.HADDR, 0);
      check_eq("rst_hwrite", ahb.HWRITE, 0);
      check_eq("rst_hsize", ahb.HSIZE, 0);
      check_eq("rst_hburst", ahb.HBURST, 0);
      check_eq("rst_hprot", ahb.HPROT, 0);
      check_eq("rst_lock", ahb.HMASTLOCK, 0);
      check_eq("rst_hwdata", ahb.HWDATA, 0);
      check_eq("rst_pq", pq, 0);
      check_eq("rst_pulses", {pack, perr}, 2'b00);
      rst = 1'b0;
      step();

      xfer(64'h1000, 3'd3, 1'b0, 64'h0, 64'hDEADBEEF_CAFEF00D, 0, 0, 1'b0, 1'b0, 1'b0, 3'b101);
      xfer(64'h2004, 3'd2, 1'b1, 64'h1234_5678, 64'h5555_AAAA_5555_AAAA, 0, 2, 1'b0, 1'b0, 1'b1, 3'b011);
      xfer(64'h3002, 3'd2, 1'b0, 64'h0, 64'h0, 0, 0, 1'b0, 1'b0, 1'b0, 3'b000);
      xfer(64'h4000, 3'd3, 1'b0, 64'h0, 64'h0BAD_0BAD_0BAD_0BAD, 0, 0, 1'b1, 1'b0, 1'b0, 3'b001);
      xfer(64'h5008, 3'd3, 1'b0, 64'h0, 64'h1111_2222_3333_4444, 0, 0, 1'b0, 1'b1, 1'b0, 3'b001);
      xfer(64'h6010, 3'd1, 1'b0, 64'h0, 64'h0000_0000_0000_BEEF, 1, 1, 1'b0, 1'b0, 1'b0, 3'b110);

      // A clear asserted in IDLE must block acceptance.
      clr = 1'b1; preq = 1'b1; padr = 64'h7000; psize = 3'd2; pwe = 1'b0;
      step();
      check_eq("clr_idle0", ahb.HTRANS, 2'b00);
      step();
      check_eq("clr_idle1", ahb.HTRANS, 2'b00);
      check_eq("clr_idle_pulse", {pack, perr}, 2'b00);
      clr = 1'b0; preq = 1'b0;
      step();

      for (int t = 0; t < 80; t++) begin
         size = 3'($urandom_range(0, 4));
         addr = {$urandom, $urandom};
         if ($urandom_range(0, 3) != 0) addr[2:0] = 3'b000;
         xfer(addr, size, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 1), $urandom_range(0, MAX_WAIT), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end

`ifdef RISCV_BIU_TIMEOUT_EN
      preq = 1'b1; padr = 64'h8000; psize = 3'd3; pwe = 1'b0; plock = 1'b0;
      ahb.HREADY = 1'b1; ahb.HRESP = 1'b0;
      step();
      step();
      ahb.HREADY = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) begin
         step();
         if (i < TIMEOUT - 1) check_eq("tmo_early", {pack, perr}, 2'b00);
      end
      check_eq("tmo_perr", perr, 1);
      check_eq("tmo_pack", pack, 0);
      check_eq("tmo_htrans", ahb.HTRANS, 2'b00);
      ahb.HREADY = 1'b1;
      step();
      preq = 1'b0;
      check_eq("tmo_idle", ahb.HTRANS, 2'b00);
      check_eq("tmo_pulse", perr, 0);
      step();
`endif

      // Asynchronous reset in the middle of a data phase abandons the transfer at once.
      preq = 1'b1; padr = 64'h9000; psize = 3'd3; pwe = 1'b1; pd = 64'hA5A5_A5A5_A5A5_A5A5; plock = 1'b1;
      ahb.HREADY = 1'b1;
      step();
      step();
      ahb.HREADY = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_eq("mrst_htrans", ahb.HTRANS, 2'b00);
      check_eq("mrst_hsel", ahb.HSEL, 0);
      check_eq("mrst_haddr", ahb.HADDR, 0);
      check_eq("mrst_hwdata", ahb.HWDATA, 0);
      check_eq("mrst_hwrite", ahb.HWRITE, 0);
      check_eq("mrst_pq", pq, 0);
      preq = 1'b0; ahb.HREADY = 1'b1;
      step();
      rst = 1'b0;
      m_pq = 64'd0; pq_known = 1'b1;
      step();
      check_eq("mrst_idle", ahb.HTRANS, 2'b00);
      xfer(64'hA000, 3'd2, 1'b0, 64'h0, 64'h0000_0000_C0DE_C0DE, 0, 1, 1'b0, 1'b0, 1'b0, 3'b010);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/riscv_biu.md
# riscv_biu

AMBA3 AHB-Lite master bus interface unit sitting directly downstream of the memory management unit. It converts the MMU's physical request (`preq`/`padr`/`psize`/`plock`/`pprot`/`pwe`/`pd`) into single, non-burst AHB-Lite transfers. It returns read data and a completion pulse (`pq_o`/`pack_o`), and flags bus errors, misaligned requests and optional timeouts on `perr_o`.

## Interface
- `XLEN`, 64, data width (32 or 64)
- `PLEN`, 64, physical address width
- `TIMEOUT`, 255, maximum data-phase wait states before abort (used only with the timeout macro)
- `clk_i`  in  1  clock, all logic on rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `clr_i`  in  1  discard pending request / suppress acknowledge
- `preq_i`  in  1  request; held stable by requester until `pack_o` or `perr_o`
- `padr_i`  in  PLEN  physical address
- `psize_i`  in  3  transfer size, AHB HSIZE encoding
- `plock_i`  in  1  locked transfer
- `pprot_i`  in  3  [0]=data/!instr, [1]=privileged, [2]=cacheable
- `pwe_i`  in  1  write enable
- `pd_i`  in  XLEN  write data
- `pq_o`  out  XLEN  read data, valid with `pack_o`
- `pack_o`  out  1  one-cycle completion pulse
- `perr_o`  out  1  one-cycle error pulse (replaces `pack_o`)
- `HSEL`, `HTRANS[1:0]`, `HADDR[PLEN-1:0]`, `HWRITE`, `HSIZE[2:0]`, `HBURST[2:0]`, `HPROT[3:0]`, `HMASTLOCK`, `HWDATA[XLEN-1:0]`  out  AHB master outputs
- `HRDATA[XLEN-1:0]`, `HREADY`, `HRESP`  in  AHB slave responses

## Operation
- State machine: IDLE, ADDR, DATA, ERR.
- IDLE:
  - Accepts `preq_i` when `clr_i`=0 and `pack_o`/`perr_o` are not asserted this cycle. The holdoff prevents re-issue of a still-held request.
  - Misalignment check: `psize_i`>log2(XLEN/8), or `padr_i` not aligned to 2^`psize_i`. On failure, `perr_o` pulses next cycle, no bus transfer, stay IDLE.
  - Otherwise: latch request, drive the address phase, go to ADDR.
- ADDR:
  - Drive `HTRANS`=NONSEQ (2'b10), `HSEL`=1, `HBURST`=SINGLE (000).
  - `HPROT`={pprot[2], 0, pprot[1], pprot[0]}.
  - On `HREADY`=1: go to DATA, `HTRANS`→IDLE, `HWDATA`←latched `pd`. Otherwise hold all outputs.
- DATA, wait until `HREADY`=1:
  - `HRESP`=OKAY: `pq_o`←`HRDATA` (reads only; writes leave `pq_o` unchanged), `pack_o` pulse, go IDLE.
  - `HRESP`=ERROR with `HREADY`=0 (first error cycle): go ERR, `HTRANS` stays IDLE.
- ERR: on `HREADY`=1, `perr_o` pulse, go IDLE.
- `clr_i`:
  - In IDLE: blocks acceptance.
  - In ADDR/DATA/ERR: the bus transfer completes normally, but the terminating `pack_o`/`perr_o` is suppressed. Latch a sticky flag cleared on return to IDLE.
- `HMASTLOCK`=latched `plock` during ADDR only.

## Timing
- Reset values: `HTRANS`=00, `HSEL`=0, `HADDR`=0, `HWRITE`=0, `HSIZE`=0, `HBURST`=000, `HPROT`=0000, `HMASTLOCK`=0, `HWDATA`=0, `pq_o`=0, `pack_o`=0, `perr_o`=0, state IDLE.
- All outputs are registered.
- Zero-wait latency: `preq_i` sampled at c0, address phase c1, data phase c2, `pack_o` c3.
- Each slave wait state adds one cycle.
- Next acceptance is no earlier than c4.
- Reset asserted mid-transfer: immediate return to reset values. The slave-side transfer is abandoned.

## Configuration
- `RISCV_BIU_TIMEOUT_EN` defined:
  - 8..16-bit counter counts consecutive `HREADY`=0 cycles in DATA/ERR.
  - Reaching `TIMEOUT` forces `perr_o` pulse (subject to `clr_i` suppression) and return to IDLE, `HTRANS`=IDLE.
  - Counter resets on every state change.
- Undefined: no counter; the BIU waits indefinitely.

## Structure
- Shared package `riscv_biu_pkg`:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ).
  - HBURST codes.
  - HSIZE codes (BYTE/HWORD/WORD/DWORD).
  - HRESP codes (OKAY/ERROR).
  - State enum.
- One sub-module, `riscv_biu_align`: combinational misalignment check (`padr`, `psize` → `misaligned`).

## Test plan
- Read, XLEN=64, `padr_i`=0x1000, `psize_i`=3, zero wait, `HRDATA`=0xDEADBEEF_CAFEF00D → `HTRANS`=10 at c1, `pack_o` at c3, `pq_o`=0xDEADBEEF_CAFEF00D.
- Write, `padr_i`=0x2004, `psize_i`=2, `pd_i`=0x1234_5678, 2 wait states → `HWRITE`=1 at c1, `HWDATA`=0x12345678 from c2, `pack_o` at c5.
- Misaligned `padr_i`=0x3002, `psize_i`=2 → `perr_o` at c1, `HTRANS` stays 00 throughout.
- Slave ERROR: `HREADY`=0/`HRESP`=1 at c2, `HREADY`=1/`HRESP`=1 at c3 → `perr_o` at c4, no `pack_o`.
- `clr_i` pulsed at c2 of a read → transfer completes on bus, no `pack_o`/`perr_o`. Next request accepted normally.
- With `RISCV_BIU_TIMEOUT_EN`, `TIMEOUT`=4, `HREADY` held 0 in DATA → `perr_o` after 4 wait cycles, state IDLE.
